// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, FSM encoding and stall-priority helper for the pipeline controller.
package pipe_ctrl_pkg;

  localparam logic        Stop     = 1'b1;
  localparam logic        NoStop   = 1'b0;
  localparam logic        Flush    = 1'b1;
  localparam logic        NoFlush  = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  typedef enum logic {
    StRun      = 1'b0,
    StBlackout = 1'b1
  } bo_state_e;

  // Deepest requesting stage wins: it freezes itself and everything upstream.
  function automatic logic [5:0] stall_mask(input logic req_if, input logic req_id,
                                            input logic req_ex, input logic req_mem);
    if (req_mem)     return STALL_MEM;
    else if (req_ex) return STALL_EX;
    else if (req_id) return STALL_ID;
    else if (req_if) return STALL_IF;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int unsigned      Width = 8,
  parameter logic [Width-1:0] Max   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != Max)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with post-flush blackout, stall watchdog and stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR      = 32'h0000_0020,
  parameter int unsigned BLACKOUT_CYCLES = 3,
  parameter int unsigned WDOG_LIMIT      = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        in_blackout,
  output logic        wdog_timeout,
  output logic        exc_dropped,
  output logic [31:0] stall_cycles
);

  localparam logic [3:0]  BoLoad  = 4'(BLACKOUT_CYCLES - 1);
  localparam logic [15:0] WdogMax = 16'(WDOG_LIMIT - 1);

  bo_state_e   state_d, state_q;
  logic [3:0]  bo_cnt_d, bo_cnt_q;
  logic        dropped_d, dropped_q;
  logic        wdog_d, wdog_q;
  logic [15:0] wdog_count;
  logic        exc_pending;
  logic        exc_accept;

  assign exc_pending = (excepttype_i != ZeroWord);
  // Gated by rst so nothing leaks onto the latch controls while held in reset.
  assign exc_accept  = rst && exc_pending && (state_q == StRun);

  always_comb begin
    stall  = STALL_NONE;
    flush  = NoFlush;
    new_pc = ZeroWord;
    if (!rst) begin
      stall = STALL_NONE;
    end else if (exc_accept) begin
      flush  = Flush;
      new_pc = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
    end else begin
      stall = stall_mask(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
    end
  end

  always_comb begin
    state_d   = state_q;
    bo_cnt_d  = bo_cnt_q;
    dropped_d = dropped_q;
    unique case (state_q)
      StRun: begin
        if (exc_accept) begin
          state_d  = StBlackout;
          bo_cnt_d = BoLoad;
        end
      end
      StBlackout: begin
        if (exc_pending) dropped_d = 1'b1;
        if (bo_cnt_q == 4'd0) begin
          state_d = StRun;
        end else begin
          bo_cnt_d = bo_cnt_q - 4'd1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Counter sits at WdogMax only after WDOG_LIMIT-1 stalled cycles; one more trips the flag.
  assign wdog_d = wdog_q | (stall[0] && (wdog_count == WdogMax));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StRun;
      bo_cnt_q  <= 4'd0;
      dropped_q <= 1'b0;
      wdog_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bo_cnt_q  <= bo_cnt_d;
      dropped_q <= dropped_d;
      wdog_q    <= wdog_d;
    end
  end

  sat_counter #(
    .Width(16),
    .Max  (WdogMax)
  ) u_wdog_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall[0]),
    .clr  (!stall[0]),
    .count(wdog_count)
  );

  sat_counter #(
    .Width(32),
    .Max  (32'hFFFF_FFFF)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall[0]),
    .clr  (1'b0),
    .count(stall_cycles)
  );

  assign in_blackout  = (state_q == StBlackout);
  assign wdog_timeout = wdog_q;
  assign exc_dropped  = dropped_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and randomized checks of pipe_ctrl against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int BoCycles = 3;
  localparam int WdLimit  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic [31:0] excepttype_i = '0, cp0_epc_i = '0;
  logic [5:0]  stall;
  logic        flush, in_blackout, wdog_timeout, exc_dropped;
  logic [31:0] new_pc, stall_cycles;

  int vectors = 0;
  int miscompares = 0;

  // Model state: remaining blackout cycles, current stalled run length, sticky flags, total.
  int     bo_left = 0;
  int     run_len = 0;
  bit     m_wd = 1'b0;
  bit     m_dropped = 1'b0;
  longint total = 0;

  pipe_ctrl #(
    .EXC_VECTOR     (32'h0000_0020),
    .BLACKOUT_CYCLES(BoCycles),
    .WDOG_LIMIT     (WdLimit)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_if (stallreq_if),
    .stallreq_id (stallreq_id),
    .stallreq_ex (stallreq_ex),
    .stallreq_mem(stallreq_mem),
    .excepttype_i(excepttype_i),
    .cp0_epc_i   (cp0_epc_i),
    .stall       (stall),
    .flush       (flush),
    .new_pc      (new_pc),
    .in_blackout (in_blackout),
    .wdog_timeout(wdog_timeout),
    .exc_dropped (exc_dropped),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    bo_left   = 0;
    run_len   = 0;
    m_wd      = 1'b0;
    m_dropped = 1'b0;
    total     = 0;
  endtask

  // Reset lands mid-cycle, away from any edge, so outputs must clear without a clock.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check_eq("rst_stall",   32'(stall),        32'd0);
    check_eq("rst_flush",   32'(flush),        32'd0);
    check_eq("rst_new_pc",  new_pc,            32'd0);
    check_eq("rst_blackout", 32'(in_blackout), 32'd0);
    check_eq("rst_wdog",    32'(wdog_timeout), 32'd0);
    check_eq("rst_dropped", 32'(exc_dropped),  32'd0);
    check_eq("rst_cycles",  stall_cycles,      32'd0);
    model_reset();
    @(negedge clk);
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0000;
    excepttype_i = '0;
    rst = 1'b1;
  endtask

  // req = {mem, ex, id, if}
  task automatic step(input logic [3:0] req, input logic [31:0] e, input logic [31:0] pc);
    bit          accept;
    logic [5:0]  es;
    logic [31:0] enpc;
    @(negedge clk);
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
    excepttype_i = e;
    cp0_epc_i    = pc;
    #1;
    accept = (e != 0) && (bo_left == 0);
    es   = 6'b000000;
    enpc = 32'h0;
    if (accept)      enpc = (e == 32'he) ? pc : 32'h20;
    else if (req[3]) es = 6'b011111;
    else if (req[2]) es = 6'b001111;
    else if (req[1]) es = 6'b000111;
    else if (req[0]) es = 6'b000011;
    check_eq("stall",        32'(stall),        32'(es));
    check_eq("flush",        32'(flush),        32'(accept));
    check_eq("new_pc",       new_pc,            enpc);
    check_eq("in_blackout",  32'(in_blackout),  32'(bo_left != 0));
    check_eq("wdog_timeout", 32'(wdog_timeout), 32'(m_wd));
    check_eq("exc_dropped",  32'(exc_dropped),  32'(m_dropped));
    check_eq("stall_cycles", stall_cycles,      total[31:0]);
    if (bo_left > 0) begin
      if (e != 0) m_dropped = 1'b1;
      bo_left--;
    end else if (accept) begin
      bo_left = BoCycles;
    end
    if (es[0]) begin
      run_len++;
      if (run_len >= WdLimit) m_wd = 1'b1;
      if (total < 64'hFFFF_FFFF) total++;
    end else begin
      run_len = 0;
    end
  endtask

  initial begin
    logic [31:0] codes [8];
    codes = '{32'h1, 32'h8, 32'h9, 32'ha, 32'hc, 32'hd, 32'he, 32'hf};

    do_reset();

    // Priority: mem beats id, then id alone.
    step(4'b1010, 32'h0, 32'h0);
    step(4'b0010, 32'h0, 32'h0);
    check_eq("prio_id", 32'(stall), 32'h07);

    // Exception overrides an EX stall; blackout spans three cycles with stalls honoured.
    step(4'b0100, 32'h8, 32'h0);
    step(4'b0100, 32'h0, 32'h0);
    step(4'b0100, 32'h0, 32'h0);
    step(4'b0100, 32'h0, 32'h0);
    step(4'b0000, 32'h0, 32'h0);

    // Drop during blackout, then acceptance in the first RUN cycle.
    step(4'b0000, 32'h8, 32'h0);
    step(4'b0000, 32'hc, 32'h0);
    step(4'b0000, 32'h0, 32'h0);
    step(4'b0000, 32'h0, 32'h0);
    step(4'b0000, 32'h1, 32'h0);
    check_eq("accept_after_bo", 32'(flush), 32'd1);
    repeat (BoCycles) step(4'b0000, 32'h0, 32'h0);

    // Eret returns to EPC.
    step(4'b0000, 32'he, 32'hBFC0_0100);
    check_eq("eret_pc", new_pc, 32'hBFC0_0100);
    repeat (BoCycles) step(4'b0000, 32'h0, 32'h0);
    check_eq("dropped_sticky", 32'(exc_dropped), 32'd1);

    // Watchdog trips on the 8th consecutive stalled cycle.
    do_reset();
    repeat (10) step(4'b0100, 32'h0, 32'h0);
    step(4'b0000, 32'h0, 32'h0);
    check_eq("wdog_10", 32'(wdog_timeout), 32'd1);
    check_eq("cycles_10", stall_cycles, 32'd10);

    // A single unstalled cycle restarts the run.
    do_reset();
    repeat (5) step(4'b0100, 32'h0, 32'h0);
    step(4'b0000, 32'h0, 32'h0);
    repeat (7) step(4'b0100, 32'h0, 32'h0);
    step(4'b0000, 32'h0, 32'h0);
    check_eq("wdog_gap", 32'(wdog_timeout), 32'd0);

    // Async reset mid-blackout with accumulated stall cycles.
    do_reset();
    repeat (5) step(4'b0001, 32'h0, 32'h0);
    step(4'b0000, 32'h8, 32'h0);
    step(4'b1000, 32'h9, 32'h0);
    check_eq("pre_rst_cycles", stall_cycles, 32'd5);
    check_eq("pre_rst_bo", 32'(in_blackout), 32'd1);
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic [3:0]  req;
      logic [31:0] e;
      req = ($urandom_range(0, 3) != 0) ? 4'($urandom) : 4'b0000;
      e   = 32'h0;
      if ($urandom_range(0, 7) == 0) begin
        e = ($urandom_range(0, 4) == 0) ? ($urandom | 32'h1) : codes[$urandom_range(0, 7)];
      end
      step(req, e, $urandom);
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
